// File: rtl/tl45_pkg.sv
// Shared Wishbone widths and bus-owner encoding for the tl45 memory/IO bus.
package tl45_pkg;

  localparam int unsigned WB_AW = 30;
  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage

// File: rtl/tl45_wb_watchdog.sv
// Bus watchdog: counts cycles without a slave response and flags a hung slave.
module tl45_wb_watchdog
  import tl45_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_timeout
);

  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

  logic [TW-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_clear) begin
      count <= '0;
    end else if (i_enable) begin
      count <= count + TW'(1);
    end
  end

  // The clear path always fires in the timeout cycle, so the count never passes the limit.
  assign o_timeout = ENABLED && (count == TW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/tl45_wb_arbiter.sv
// Two-master (fetch A, memory B) to one-slave pipelined Wishbone arbiter with a
// grant held for the whole CYC and a watchdog that turns a hung slave into ERR.
module tl45_wb_arbiter
  import tl45_pkg::*;
#(
  parameter bit          OPT_ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES  = 255,
  parameter int unsigned TW              = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,

  input  logic             i_a_cyc,
  input  logic             i_a_stb,
  input  logic             i_a_we,
  input  logic [WB_AW-1:0] i_a_addr,
  input  logic [WB_DW-1:0] i_a_data,
  input  logic [WB_SW-1:0] i_a_sel,
  output logic             o_a_ack,
  output logic             o_a_stall,
  output logic             o_a_err,
  output logic [WB_DW-1:0] o_a_data,

  input  logic             i_b_cyc,
  input  logic             i_b_stb,
  input  logic             i_b_we,
  input  logic [WB_AW-1:0] i_b_addr,
  input  logic [WB_DW-1:0] i_b_data,
  input  logic [WB_SW-1:0] i_b_sel,
  output logic             o_b_ack,
  output logic             o_b_stall,
  output logic             o_b_err,
  output logic [WB_DW-1:0] o_b_data,

  output logic             o_wb_cyc,
  output logic             o_wb_stb,
  output logic             o_wb_we,
  output logic [WB_AW-1:0] o_wb_addr,
  output logic [WB_DW-1:0] o_wb_data,
  output logic [WB_SW-1:0] o_wb_sel,
  input  logic             i_wb_ack,
  input  logic             i_wb_stall,
  input  logic             i_wb_err,
  input  logic [WB_DW-1:0] i_wb_data,

  output logic [1:0]       o_owner
);

  owner_e owner, owner_nxt;
  logic   last_b, last_b_nxt;   // last_served: 0 = A, 1 = B
  logic   own_cyc;
  logic   wb_event;
  logic   wd_expired;
  logic   timeout;

  assign own_cyc  = ((owner == OWN_A) && i_a_cyc) || ((owner == OWN_B) && i_b_cyc);
  assign wb_event = i_wb_ack || i_wb_err;
  // A slave response in the limit cycle wins over the forced error.
  assign timeout  = wd_expired && own_cyc && !wb_event;

  tl45_wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TW             (TW)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (!own_cyc || wb_event || timeout),
    .i_enable  (own_cyc),
    .o_timeout (wd_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      owner  <= OWN_NONE;
      last_b <= 1'b0;
    end else begin
      owner  <= owner_nxt;
      last_b <= last_b_nxt;
    end
  end

  always_comb begin
    owner_nxt  = owner;
    last_b_nxt = last_b;
    o_wb_cyc   = 1'b0;
    o_wb_stb   = 1'b0;
    o_wb_we    = 1'b0;
    o_wb_addr  = '0;
    o_wb_data  = '0;
    o_wb_sel   = '0;
    o_a_ack    = 1'b0;
    o_a_err    = 1'b0;
    o_a_data   = '0;
    o_a_stall  = i_a_cyc;
    o_b_ack    = 1'b0;
    o_b_err    = 1'b0;
    o_b_data   = '0;
    o_b_stall  = i_b_cyc;

    case (owner)
      OWN_NONE: begin
        if (i_a_cyc && i_b_cyc) begin
          owner_nxt = (OPT_ROUND_ROBIN && last_b) ? OWN_A : OWN_B;
        end else if (i_a_cyc) begin
          owner_nxt = OWN_A;
        end else if (i_b_cyc) begin
          owner_nxt = OWN_B;
        end
      end

      OWN_A: begin
        o_wb_cyc  = i_a_cyc && !timeout;
        o_wb_stb  = i_a_cyc && i_a_stb && !timeout;
        o_wb_we   = i_a_we;
        o_wb_addr = i_a_addr;
        o_wb_data = i_a_data;
        o_wb_sel  = i_a_sel;
        o_a_ack   = i_wb_ack && i_a_cyc;
        o_a_err   = (i_wb_err && i_a_cyc) || timeout;
        o_a_stall = i_wb_stall;
        o_a_data  = i_wb_data;
        // Release hands the bus straight to a waiting B with no idle cycle.
        if (!i_a_cyc) begin
          last_b_nxt = 1'b0;
          owner_nxt  = i_b_cyc ? OWN_B : OWN_NONE;
        end else if (timeout) begin
          last_b_nxt = 1'b0;
          owner_nxt  = OWN_NONE;
        end
      end

      OWN_B: begin
        o_wb_cyc  = i_b_cyc && !timeout;
        o_wb_stb  = i_b_cyc && i_b_stb && !timeout;
        o_wb_we   = i_b_we;
        o_wb_addr = i_b_addr;
        o_wb_data = i_b_data;
        o_wb_sel  = i_b_sel;
        o_b_ack   = i_wb_ack && i_b_cyc;
        o_b_err   = (i_wb_err && i_b_cyc) || timeout;
        o_b_stall = i_wb_stall;
        o_b_data  = i_wb_data;
        if (!i_b_cyc) begin
          last_b_nxt = 1'b1;
          owner_nxt  = i_a_cyc ? OWN_A : OWN_NONE;
        end else if (timeout) begin
          last_b_nxt = 1'b1;
          owner_nxt  = OWN_NONE;
        end
      end

      default: begin
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  assign o_owner = owner;

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Bench for tl45_wb_arbiter: a round-robin and a fixed-priority instance share
// stimulus; directed scenarios then random traffic against a reference model.
module tb_tl45_wb_arbiter;
  import tl45_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             a_cyc, a_stb, a_we, b_cyc, b_stb, b_we;
  logic [WB_AW-1:0] a_addr, b_addr;
  logic [WB_DW-1:0] a_data, b_data;
  logic [WB_SW-1:0] a_sel, b_sel;
  logic             wb_ack, wb_stall, wb_err;
  logic [WB_DW-1:0] wb_data;

  logic [1:0]       owner_o [2];
  logic             wbc_o [2], wbs_o [2], wbw_o [2];
  logic [WB_AW-1:0] wba_o [2];
  logic [WB_DW-1:0] wbd_o [2];
  logic [WB_SW-1:0] wbsel_o [2];
  logic             aack_o [2], astall_o [2], aerr_o [2];
  logic [WB_DW-1:0] adat_o [2];
  logic             back_o [2], bstall_o [2], berr_o [2];
  logic [WB_DW-1:0] bdat_o [2];

  // Instance 0: round-robin; instance 1: fixed priority (B over A).
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    tl45_wb_arbiter #(
      .OPT_ROUND_ROBIN (g == 0),
      .TIMEOUT_CYCLES  (TMO),
      .TW              (8)
    ) u_dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_a_cyc    (a_cyc),
      .i_a_stb    (a_stb),
      .i_a_we     (a_we),
      .i_a_addr   (a_addr),
      .i_a_data   (a_data),
      .i_a_sel    (a_sel),
      .o_a_ack    (aack_o[g]),
      .o_a_stall  (astall_o[g]),
      .o_a_err    (aerr_o[g]),
      .o_a_data   (adat_o[g]),
      .i_b_cyc    (b_cyc),
      .i_b_stb    (b_stb),
      .i_b_we     (b_we),
      .i_b_addr   (b_addr),
      .i_b_data   (b_data),
      .i_b_sel    (b_sel),
      .o_b_ack    (back_o[g]),
      .o_b_stall  (bstall_o[g]),
      .o_b_err    (berr_o[g]),
      .o_b_data   (bdat_o[g]),
      .o_wb_cyc   (wbc_o[g]),
      .o_wb_stb   (wbs_o[g]),
      .o_wb_we    (wbw_o[g]),
      .o_wb_addr  (wba_o[g]),
      .o_wb_data  (wbd_o[g]),
      .o_wb_sel   (wbsel_o[g]),
      .i_wb_ack   (wb_ack),
      .i_wb_stall (wb_stall),
      .i_wb_err   (wb_err),
      .i_wb_data  (wb_data),
      .o_owner    (owner_o[g])
    );
  end

  int checks = 0;
  int passed = 0;

  // Reference model: owner 0/1/2, last served 1=A 2=B, silent cycles since grant/response.
  int m_owner [2];
  int m_last  [2];
  int m_quiet [2];

  logic             log_en;
  logic             saw_a_ack;
  logic [WB_DW-1:0] wq [$];

  task automatic chk32(int k, string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL d%0d.%s: observed 0x%0h expected 0x%0h", k, name, obs, exp);
  endtask

  task automatic chk1(int k, string name, logic obs, logic exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL d%0d.%s: observed %b expected %b", k, name, obs, exp);
  endtask

  function automatic logic m_req(int who);
    return (who == 1) ? a_cyc : (who == 2) ? b_cyc : 1'b0;
  endfunction

  function automatic logic m_hung(int k);
    return (m_owner[k] != 0) && m_req(m_owner[k]) && (m_quiet[k] == TMO) && !wb_ack && !wb_err;
  endfunction

  function automatic logic [34:0] m_resp(logic owns, logic cyc, logic hung);
    if (owns) return {wb_ack & cyc, wb_stall, (wb_err & cyc) | hung, wb_data};
    return {1'b0, cyc, 1'b0, 32'h0};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = 0;
      m_last[k]  = 1;
      m_quiet[k] = 0;
    end
  endtask

  task automatic model_edge();
    int   own;
    logic hung;
    for (int k = 0; k < 2; k++) begin
      own  = m_owner[k];
      hung = m_hung(k);
      if (!rst_n) begin
        m_owner[k] = 0;
        m_last[k]  = 1;
        m_quiet[k] = 0;
      end else if (own == 0) begin
        m_quiet[k] = 0;
        if (a_cyc && b_cyc) m_owner[k] = (k == 0 && m_last[k] == 2) ? 1 : 2;
        else if (a_cyc)     m_owner[k] = 1;
        else if (b_cyc)     m_owner[k] = 2;
      end else if (!m_req(own) || hung) begin
        m_last[k]  = own;
        m_quiet[k] = 0;
        m_owner[k] = (!m_req(own) && m_req(3 - own)) ? 3 - own : 0;
      end else if (wb_ack || wb_err) begin
        m_quiet[k] = 0;
      end else begin
        m_quiet[k] = m_quiet[k] + 1;
      end
    end
  endtask

  task automatic check_dut(int k);
    int               own;
    logic             hung, live;
    logic             ostb, owe;
    logic [WB_AW-1:0] oaddr;
    logic [WB_DW-1:0] odata;
    logic [WB_SW-1:0] osel;
    logic [34:0]      ea, eb;
    own  = m_owner[k];
    hung = m_hung(k);
    live = (own != 0) && m_req(own) && !hung;
    ostb = 1'b0; owe = 1'b0; oaddr = '0; odata = '0; osel = '0;
    if (own == 1) begin
      ostb = a_stb; owe = a_we; oaddr = a_addr; odata = a_data; osel = a_sel;
    end else if (own == 2) begin
      ostb = b_stb; owe = b_we; oaddr = b_addr; odata = b_data; osel = b_sel;
    end
    ea = m_resp(own == 1, a_cyc, hung);
    eb = m_resp(own == 2, b_cyc, hung);
    chk32(k, "owner",   32'(owner_o[k]), 32'(own));
    chk1 (k, "wb_cyc",  wbc_o[k], live);
    chk1 (k, "wb_stb",  wbs_o[k], live && ostb);
    chk1 (k, "wb_we",   wbw_o[k], owe);
    chk32(k, "wb_addr", 32'(wba_o[k]), 32'(oaddr));
    chk32(k, "wb_data", wbd_o[k], odata);
    chk32(k, "wb_sel",  32'(wbsel_o[k]), 32'(osel));
    chk1 (k, "a_ack",   aack_o[k], ea[34]);
    chk1 (k, "a_stall", astall_o[k], ea[33]);
    chk1 (k, "a_err",   aerr_o[k], ea[32]);
    chk32(k, "a_data",  adat_o[k], ea[31:0]);
    chk1 (k, "b_ack",   back_o[k], eb[34]);
    chk1 (k, "b_stall", bstall_o[k], eb[33]);
    chk1 (k, "b_err",   berr_o[k], eb[32]);
    chk32(k, "b_data",  bdat_o[k], eb[31:0]);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    @(negedge clk);
    if (!rst_n) model_reset();
    check_dut(0);
    check_dut(1);
    if (log_en) begin
      if (wbc_o[1] && wbs_o[1] && !wb_stall) wq.push_back(wbd_o[1]);
      if (aack_o[0] || aack_o[1]) saw_a_ack = 1'b1;
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    a_cyc = 0; a_stb = 0; a_we = 0; a_addr = '0; a_data = '0; a_sel = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_addr = '0; b_data = '0; b_sel = '0;
    wb_ack = 0; wb_stall = 0; wb_err = 0; wb_data = '0;
  endtask

  initial begin
    log_en = 1'b0;
    saw_a_ack = 1'b0;
    idle();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      chk32(k, "rst.owner", 32'(owner_o[k]), 32'd0);
      chk1 (k, "rst.wb_cyc", wbc_o[k], 1'b0);
    end
    rst_n = 1'b1;
    step();

    // A alone reads 0x100
    a_cyc = 1; a_stb = 1; a_addr = 30'h100;
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "rd.stall_arb", astall_o[k], 1'b1);
    step();
    settle();
    for (int k = 0; k < 2; k++) begin
      chk1 (k, "rd.wb_stb", wbs_o[k], 1'b1);
      chk32(k, "rd.wb_addr", 32'(wba_o[k]), 32'h100);
      chk32(k, "rd.owner", 32'(owner_o[k]), 32'd1);
    end
    step();
    a_stb = 0; wb_ack = 1; wb_data = 32'hDEADBEEF;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk1 (k, "rd.ack", aack_o[k], 1'b1);
      chk32(k, "rd.data", adat_o[k], 32'hDEADBEEF);
    end
    step();
    wb_ack = 0; a_cyc = 0;
    step();
    step();

    // Contention with last_served = A: B first, then A with no idle cycle
    a_cyc = 1; a_stb = 1; b_cyc = 1; b_stb = 1; b_addr = 30'h200;
    step();
    settle();
    for (int k = 0; k < 2; k++) begin
      chk32(k, "cont.owner_b", 32'(owner_o[k]), 32'd2);
      chk1 (k, "cont.a_stall", astall_o[k], 1'b1);
    end
    step();
    b_stb = 0; wb_ack = 1; wb_data = 32'h55;
    step();
    wb_ack = 0; b_cyc = 0;
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "cont.drop_cyc", wbc_o[k], 1'b0);
    step();
    settle();
    for (int k = 0; k < 2; k++) chk32(k, "cont.owner_a", 32'(owner_o[k]), 32'd1);
    step();
    a_stb = 0; wb_ack = 1;
    step();
    wb_ack = 0; a_cyc = 0;
    step();
    step();

    // B holds the bus for three writes, first one stalled twice; A waits
    wq.delete();
    log_en = 1'b1; saw_a_ack = 1'b0;
    a_cyc = 1; a_stb = 1;
    b_cyc = 1; b_stb = 1; b_we = 1; b_data = 32'h11; b_sel = 4'hF;
    step();
    wb_stall = 1;
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "wr.stall1", bstall_o[k], 1'b1);
    step();
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "wr.stall2", bstall_o[k], 1'b1);
    step();
    wb_stall = 0;
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "wr.stall_off", bstall_o[k], 1'b0);
    step();
    b_data = 32'h22; wb_ack = 1;
    step();
    b_data = 32'h33;
    step();
    b_stb = 0;
    step();
    wb_ack = 0; b_cyc = 0; b_we = 0;
    step();
    log_en = 1'b0;
    chk32(1, "wr.count", 32'(wq.size()), 32'd3);
    if (wq.size() == 3) begin
      chk32(1, "wr.w0", wq[0], 32'h11);
      chk32(1, "wr.w1", wq[1], 32'h22);
      chk32(1, "wr.w2", wq[2], 32'h33);
    end
    chk1(1, "wr.no_a_ack", saw_a_ack, 1'b0);
    settle();
    for (int k = 0; k < 2; k++) chk32(k, "wr.owner_a", 32'(owner_o[k]), 32'd1);
    a_cyc = 0; a_stb = 0;
    step();
    step();

    // Hung slave: error in the cycle the silent count reaches the limit
    b_cyc = 1; b_stb = 1; b_addr = 30'h300;
    step();
    for (int i = 1; i <= TMO + 1; i++) begin
      settle();
      for (int k = 0; k < 2; k++) begin
        chk1(k, $sformatf("tmo.err_c%0d", i), berr_o[k], i == TMO + 1);
        chk1(k, $sformatf("tmo.cyc_c%0d", i), wbc_o[k], i != TMO + 1);
      end
      step();
      b_stb = 0;
    end
    b_cyc = 0;
    settle();
    for (int k = 0; k < 2; k++) chk32(k, "tmo.owner_none", 32'(owner_o[k]), 32'd0);
    step();
    step();

    // ACK arriving in the limit cycle wins over the timeout
    b_cyc = 1; b_stb = 1;
    step();
    step();
    b_stb = 0;
    step();
    step();
    step();
    wb_ack = 1; wb_data = 32'hCAFE;
    settle();
    for (int k = 0; k < 2; k++) begin
      chk1(k, "race.ack", back_o[k], 1'b1);
      chk1(k, "race.err", berr_o[k], 1'b0);
      chk1(k, "race.cyc", wbc_o[k], 1'b1);
    end
    step();
    wb_ack = 0;
    settle();
    for (int k = 0; k < 2; k++) chk32(k, "race.owner", 32'(owner_o[k]), 32'd2);
    b_cyc = 0;
    step();
    step();

    // Asynchronous reset while A owns the bus with STB high
    a_cyc = 1; a_stb = 1; a_addr = 30'h40;
    step();
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "ar.stb_before", wbs_o[k], 1'b1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      chk1 (k, "ar.cyc", wbc_o[k], 1'b0);
      chk1 (k, "ar.stb", wbs_o[k], 1'b0);
      chk32(k, "ar.owner", 32'(owner_o[k]), 32'd0);
    end
    step();
    rst_n = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) chk1(k, "ar.rearb_stall", astall_o[k], 1'b1);
    step();
    settle();
    for (int k = 0; k < 2; k++) chk32(k, "ar.owner_a", 32'(owner_o[k]), 32'd1);
    a_cyc = 0; a_stb = 0;
    step();
    step();

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(5) == 0) a_cyc = ~a_cyc;
      if ($urandom_range(5) == 0) b_cyc = ~b_cyc;
      a_stb    = a_cyc & 1'($urandom_range(1));
      b_stb    = b_cyc & 1'($urandom_range(1));
      a_we     = 1'($urandom_range(1));
      b_we     = 1'($urandom_range(1));
      a_addr   = 30'($urandom);
      b_addr   = 30'($urandom);
      a_data   = $urandom;
      b_data   = $urandom;
      a_sel    = 4'($urandom);
      b_sel    = 4'($urandom);
      wb_ack   = ($urandom_range(4) == 0);
      wb_err   = ($urandom_range(31) == 0);
      wb_stall = ($urandom_range(3) == 0);
      wb_data  = $urandom;
      rst_n    = ($urandom_range(399) != 0);
      step();
    end

    rst_n = 1'b1;
    idle();
    step();
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tl45_wb_arbiter.md
Name: tl45_wb_arbiter

Overview:
Two-master to one-slave Wishbone (pipelined, B4) arbiter for the tl45 core. Master A is instruction fetch; master B is the memory stage (LW/SW path). It shares the single 30-bit word-addressed memory/IO bus between them. The grant is held for the full duration of a master's CYC. A watchdog converts a hung slave into a bus error for the owner.

Parameters:
OPT_ROUND_ROBIN, 1, 1 = alternate grant on contention; 0 = fixed priority, B over A
TIMEOUT_CYCLES, 255, cycles without slave ACK/ERR while granted before forced error; 0 disables the watchdog
TW, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_a_cyc, i_a_stb, i_a_we  in  1 each  master A bus request
i_a_addr  in  30  master A word address
i_a_data  in  32  master A write data
i_a_sel  in  4  master A byte select
o_a_ack, o_a_stall, o_a_err  out  1 each  master A responses
o_a_data  out  32  master A read data
i_b_*/o_b_*  same set and widths as A  master B (memory stage)
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  to slave
o_wb_addr  out  30  to slave
o_wb_data  out  32  to slave
o_wb_sel  out  4  to slave
i_wb_ack, i_wb_stall, i_wb_err  in  1 each  from slave
i_wb_data  in  32  from slave
o_owner  out  2  0 = none, 1 = A, 2 = B (debug/formal)

Behaviour:
- State: owner register {NONE, A, B}, last_served bit, timeout counter.
- Reset: async on i_reset_n low. owner = NONE, last_served = A, counter = 0.
- Every output is 0 in reset and whenever owner = NONE, except non-owner stall (below). Reset mid-transaction drops o_wb_cyc immediately.
- Arbitration is registered, with a 1-cycle latency:
  - A master raising CYC while owner = NONE sees o_x_stall = 1 in that cycle.
  - owner updates at the next edge.
  - Passthrough starts in the cycle after that.
- Contention (both CYC while owner = NONE):
  - OPT_ROUND_ROBIN = 1: grant the master that is not last_served.
  - OPT_ROUND_ROBIN = 0: grant B.
- Passthrough while owner = X:
  - o_wb_cyc/stb/we/addr/data/sel = X inputs, combinationally.
  - o_x_ack = i_wb_ack, o_x_err = i_wb_err, o_x_stall = i_wb_stall, o_x_data = i_wb_data.
- Non-owner with CYC high: o_y_stall = 1; o_y_ack, o_y_err = 0; o_y_data = 0.
- Release: when the owner drops CYC, at that edge owner <= arbitration result over the other master's CYC.
  - The other master can be granted directly, with no idle cycle.
  - last_served <= releasing master.
  - The released master cannot be re-granted on the same edge if the other is requesting (round-robin mode).
- Owner-not-requesting rule: o_wb_cyc is gated by the owner's CYC. An owner dropping CYC therefore ends the slave cycle combinationally. Late ACKs after the drop are discarded.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Counter clears when owner = NONE, or on i_wb_ack or i_wb_err.
  - Otherwise it increments each cycle while the owner's CYC is high.
  - When counter == TIMEOUT_CYCLES: pulse o_x_err = 1 to the owner for 1 cycle, and force o_wb_cyc/stb = 0 in that cycle.
  - owner <= NONE at that edge; counter <= 0.
  - The master is expected to drop CYC on ERR.
- Simultaneous events:
  - Slave ACK in the timeout cycle: ACK wins and the counter clears; no error.
  - Owner drop in the same cycle as the timeout: no error; normal release.
- No address decode; the slave-side IO mapping is unchanged.

Decomposition:
- Package tl45_pkg: owner enum (OWN_NONE, OWN_A, OWN_B), WB_AW = 30, WB_DW = 32, WB_SW = 4.
- One natural sub-module: tl45_wb_watchdog (counter, clear/enable inputs, timeout pulse output). Everything else stays flat.

Test Plan:
- A alone reads 0x100: cyc/stb at t0 -> o_a_stall = 1 at t0; o_wb_stb = 1, addr = 0x100 at t1; slave ACK data 0xDEADBEEF at t2 -> o_a_ack = 1, o_a_data = 0xDEADBEEF; o_owner = 1.
- A and B raise CYC together, RR = 1, last_served = A -> B granted (o_owner = 2) and A stalled. When B drops CYC, o_owner = 1 at the next edge with no idle cycle.
- RR = 0, B holds the bus for 3 SW writes of 0x11/0x22/0x33 with slave stall = 1 for 2 cycles on the first -> o_b_stall mirrors the slave; all 3 writes appear in order on o_wb_data; A never sees ACK.
- TIMEOUT_CYCLES = 4, slave never ACKs B's read -> o_b_err = 1 exactly at the 4th count cycle; o_wb_cyc = 0 that cycle; o_owner = 0 next cycle.
- Slave ACK in the same cycle the counter reaches TIMEOUT -> o_b_ack = 1, o_b_err = 0, owner retained.
- i_reset_n low while A owns with stb high -> o_wb_cyc/stb = 0 immediately (asynchronous); o_owner = 0; after release A re-arbitrates with 1-cycle latency.
